// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter between
// writeback and the debug/formal-harness requester.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2,
    ACK   = 2'd3
  } rf_arb_state_t;

  // x0 is hardwired to zero: writes to it are dropped and reads return 0.
  localparam int RF_X0 = 0;

  // Width of a counter that must hold the value max itself.
  function automatic int starve_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/rf_arb_starve_cnt.sv
// Saturating count of consecutive cycles a debug request lost to writeback;
// hit flags the cycle whose increment lands on STARVE_MAX.
module rf_arb_starve_cnt
  import rf_arb_pkg::*;
#(
  parameter  int STARVE_MAX = 8,
  localparam int CNT_W      = starve_w(STARVE_MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX))
      cnt_d = cnt_q + 1'b1;
  end

  assign hit = inc && !clr && (cnt_d == MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the integer register file write port and one registered read port
// between writeback (always wins) and a debug requester with starvation stall.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int AR_BITS    = 5,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we_i,
  input  logic [AR_BITS-1:0] wb_dst_i,
  input  logic [XLEN-1:0]    wb_r_i,
  input  logic               dbg_req_i,
  input  logic               dbg_we_i,
  input  logic [AR_BITS-1:0] dbg_addr_i,
  input  logic [XLEN-1:0]    dbg_wdata_i,
  output logic               dbg_ack_o,
  output logic [XLEN-1:0]    dbg_rdata_o,
  output logic               rf_we_o,
  output logic [AR_BITS-1:0] rf_dst_o,
  output logic [XLEN-1:0]    rf_r_o,
  output logic [AR_BITS-1:0] rf_rd_addr_o,
  output logic               rf_rd_en_o,
  input  logic [XLEN-1:0]    rf_rd_q_i,
  output logic               pipe_stall_o
);

  localparam logic [AR_BITS-1:0] X0 = AR_BITS'(RF_X0);

  rf_arb_state_t     state_q, state_d;
  logic              stall_q;
  logic              op_rd_q;
  logic              op_x0_q;
  logic [XLEN-1:0]   rdata_q;
  logic              grant;
  logic              blocked;
  logic              starve_hit;

  // Gating with rst keeps a grant from issuing a write or read strobe while
  // reset is asserted mid-operation.
  assign grant   = !rst && (state_q != ACK) && dbg_req_i && !wb_we_i;
  assign blocked = dbg_req_i && wb_we_i && ((state_q == IDLE) || (state_q == WAIT));

  rf_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (grant),
    .inc (blocked),
    .hit (starve_hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WAIT: begin
        if (!dbg_req_i)     state_d = IDLE;
        else if (!wb_we_i)  state_d = ACK;
        else if (starve_hit) state_d = STALL;
        else                state_d = WAIT;
      end
      STALL: begin
        if (!dbg_req_i)     state_d = IDLE;
        else if (!wb_we_i)  state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback owns the write port whenever it asks; debug only sees it on grant.
  always_comb begin
    rf_we_o      = !rst && (wb_we_i || (grant && dbg_we_i && (dbg_addr_i != X0)));
    rf_dst_o     = wb_we_i ? wb_dst_i : dbg_addr_i;
    rf_r_o       = wb_we_i ? wb_r_i   : dbg_wdata_i;
    rf_rd_en_o   = grant && !dbg_we_i;
    rf_rd_addr_o = dbg_addr_i;
  end

  // Read data is passed through live in ACK and held afterwards.
  assign dbg_ack_o    = (state_q == ACK);
  assign dbg_rdata_o  = (dbg_ack_o && op_rd_q) ? (op_x0_q ? '0 : rf_rd_q_i) : rdata_q;
  assign pipe_stall_o = stall_q;

  // NOTE: reset covers only control and small data registers; the register
  // file storage itself lives outside this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      op_rd_q <= 1'b0;
      op_x0_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == STALL);
      if (grant) begin
        op_rd_q <= !dbg_we_i;
        op_x0_q <= (dbg_addr_i == X0);
      end
      if (dbg_ack_o)
        rdata_q <= dbg_rdata_o;
    end
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter with a behavioural register file model.
module tb_rf_port_arbiter;
  import rf_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_dst = '0;
  logic [31:0] wb_r = '0;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;
  logic        rf_we_o;
  logic [4:0]  rf_dst_o;
  logic [31:0] rf_r_o;
  logic [4:0]  rf_rd_addr_o;
  logic        rf_rd_en_o;
  logic [31:0] rf_q;
  logic        pipe_stall_o;
  logic        force_q = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { logic [31:0] rd; int cyc; } ack_exp_t;
  typedef struct { logic [4:0] dst; logic [31:0] d; } wr_exp_t;
  ack_exp_t sb[$];
  wr_exp_t  wq[$];
  logic [31:0] regs [32];

  rf_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wb_we_i      (wb_we),
    .wb_dst_i     (wb_dst),
    .wb_r_i       (wb_r),
    .dbg_req_i    (dbg_req),
    .dbg_we_i     (dbg_we),
    .dbg_addr_i   (dbg_addr),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_ack_o    (dbg_ack_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .rf_we_o      (rf_we_o),
    .rf_dst_o     (rf_dst_o),
    .rf_r_o       (rf_r_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_en_o   (rf_rd_en_o),
    .rf_rd_q_i    (rf_q),
    .pipe_stall_o (pipe_stall_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: one-cycle registered read, x0 unless forced reads 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rf_q <= '0;
    end else begin
      if (rf_rd_en_o)
        rf_q <= force_q ? 32'h1234 : ((rf_rd_addr_o == 5'd0) ? 32'h0 : regs[rf_rd_addr_o]);
      if (rf_we_o)
        regs[rf_dst_o] <= rf_r_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops ack and write expectations whenever the DUT presents them.
  always @(negedge clk) begin
    if (dbg_ack_o) begin
      if (sb.size() == 0) check("unexpected_ack", 1, 0);
      else begin
        ack_exp_t e;
        e = sb.pop_front();
        check("ack_rdata", dbg_rdata_o, e.rd);
        check("ack_cycle", cyc, e.cyc);
      end
    end
    if (rf_we_o) begin
      if (wq.size() == 0) check("unexpected_write", {27'd0, rf_dst_o}, 32'hFFFF_FFFF);
      else begin
        wr_exp_t w;
        w = wq.pop_front();
        check("wr_dst", {27'd0, rf_dst_o}, {27'd0, w.dst});
        check("wr_data", rf_r_o, w.d);
      end
    end
    if (!rst && (dut.state_q == WAIT || dut.state_q == STALL))
      check("req_held", {31'd0, dbg_req}, 32'd1);
  end

  // Issue one debug op; WB writes wb_dst/wb_r for the first wb_hold cycles.
  task automatic op(input logic we, input logic [4:0] a, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input int lat, input int wb_hold);
    int k = 0;
    bit got = 0;
    bit dbg_pushed = 0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    sb.push_back('{exp_rd, cyc + lat});
    while (k < 64 && !got) begin
      wb_we = (k < wb_hold);
      if (wb_we) wq.push_back('{wb_dst, wb_r});
      else if (!dbg_pushed) begin
        dbg_pushed = 1;
        if (we && a != 5'd0) wq.push_back('{a, wd});
      end
      @(negedge clk);
      if (dbg_ack_o) got = 1;
      @(posedge clk); #1;
      k++;
    end
    wb_we = 1'b0;
    dbg_req = 1'b0;
    if (!got) check("ack_timeout", 0, 1);
  endtask

  initial begin
    wb_we = 1'b1; wb_dst = 5'd1; wb_r = 32'h99;
    #12;
    check("rst_rf_we", {31'd0, rf_we_o}, 0);
    check("rst_rd_en", {31'd0, rf_rd_en_o}, 0);
    check("rst_ack", {31'd0, dbg_ack_o}, 0);
    check("rst_rdata", dbg_rdata_o, 0);
    check("rst_stall", {31'd0, pipe_stall_o}, 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    wb_we = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    op(1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1, 0);
    op(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 1, 0);
    force_q = 1'b1;
    op(1'b0, 5'd0, 32'h0, 32'h0, 1, 0);
    force_q = 1'b0;
    op(1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 1, 0);
    op(1'b1, 5'd0, 32'h123, 32'hDEADBEEF, 1, 0);

    wb_dst = 5'd7; wb_r = 32'h11;
    op(1'b1, 5'd7, 32'h22, 32'hDEADBEEF, 2, 1);
    op(1'b0, 5'd7, 32'h0, 32'h22, 1, 0);

    wb_dst = 5'd3; wb_r = 32'h33;
    fork
      op(1'b0, 5'd3, 32'h0, 32'h33, 11, 10);
      begin
        for (int i = 0; i <= 11; i++) begin
          @(negedge clk);
          check($sformatf("stall_c%0d", i), {31'd0, pipe_stall_o}, (i >= 8 && i <= 10) ? 32'd1 : 32'd0);
        end
      end
    join

    op(1'b1, 5'd9,  32'hA5A5, 32'h33, 1, 0);
    op(1'b1, 5'd10, 32'h5A5A, 32'h33, 1, 0);
    op(1'b0, 5'd9,  32'h0, 32'hA5A5, 1, 0);
    op(1'b0, 5'd10, 32'h0, 32'h5A5A, 1, 0);

    // Reset abandons a granted read before its ACK cycle.
    wb_dst = 5'd4; wb_r = 32'h44;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7; wb_we = 1'b1;
    repeat (3) begin
      wq.push_back('{wb_dst, wb_r});
      @(posedge clk); #1;
    end
    check("cnt_blocked", 32'(dut.u_starve.cnt_q), 32'd3);
    check("state_wait", 32'(dut.state_q), 32'(WAIT));
    wb_we = 1'b0;
    @(negedge clk);
    check("grant_rd_en", {31'd0, rf_rd_en_o}, 1);
    #1 rst = 1'b1;
    #1 check("rst_kills_rd_en", {31'd0, rf_rd_en_o}, 0);
    @(posedge clk); #1 dbg_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ack", {31'd0, dbg_ack_o}, 0);
      check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
      check("post_rst_stall", {31'd0, pipe_stall_o}, 0);
      check("post_rst_cnt", 32'(dut.u_starve.cnt_q), 0);
    end
    check("post_rst_rdata", dbg_rdata_o, 0);

    check("ack_queue_empty", sb.size(), 0);
    check("wr_queue_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the integer register file's single write port and one registered read port between pipeline writeback (WB) and a debug/formal-harness requester.
- WB always wins a same-cycle conflict. A starvation counter forces a pipeline stall so the debug request is guaranteed to complete.
- Sits between wb_unit and int_rf in the core.

Parameters:
XLEN, 32, register data width
AR_BITS, 5, register index width
STARVE_MAX, 8, consecutive WB-blocked cycles before stall is forced (>=1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
wb_we_i  in  1  WB write request
wb_dst_i  in  AR_BITS  WB destination index
wb_r_i  in  XLEN  WB write data
dbg_req_i  in  1  debug request; held, fields stable, until dbg_ack_o
dbg_we_i  in  1  1=write, 0=read
dbg_addr_i  in  AR_BITS  debug register index
dbg_wdata_i  in  XLEN  debug write data
dbg_ack_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  XLEN  read data, valid with dbg_ack_o
rf_we_o  out  1  register file write enable
rf_dst_o  out  AR_BITS  register file write index
rf_r_o  out  XLEN  register file write data
rf_rd_addr_o  out  AR_BITS  debug read index to register file
rf_rd_en_o  out  1  debug read strobe
rf_rd_q_i  in  XLEN  register file read data, one cycle after strobe
pipe_stall_o  out  1  freeze request to pipeline

Behaviour:
- States: IDLE, WAIT, STALL, ACK.
- Reset values: state=IDLE, starve_cnt=0, dbg_ack_o=0, dbg_rdata_o=0, pipe_stall_o=0, and rf_we_o=0 / rf_rd_en_o=0 while rst=1.
- WB path is combinational:
  - wb_we_i=1 => rf_we_o=1, rf_dst_o=wb_dst_i, rf_r_o=wb_r_i, in the same cycle, in every state.
- Grant condition: state in {IDLE, WAIT, STALL} && dbg_req_i && !wb_we_i.
- On grant in cycle N:
  - Write: rf_we_o=1, rf_dst_o=dbg_addr_i, rf_r_o=dbg_wdata_i in cycle N. If dbg_addr_i==0, rf_we_o stays 0 and the write is dropped.
  - Read: rf_rd_en_o=1, rf_rd_addr_o=dbg_addr_i in cycle N.
  - Next state ACK; starve_cnt cleared.
- ACK (cycle N+1):
  - dbg_ack_o=1.
  - dbg_rdata_o = rf_rd_q_i for a read (0 if index 0); holds its previous value for a write.
  - dbg_req_i is ignored; next state IDLE.
  - Max throughput is one debug op per 2 cycles.
- Blocked request (dbg_req_i && wb_we_i) in IDLE/WAIT:
  - starve_cnt increments; state becomes WAIT.
  - When the increment reaches STARVE_MAX, the next state is STALL.
- Cycles in WAIT with wb_we_i=0 grant immediately.
- STALL:
  - pipe_stall_o=1, registered, asserted from the cycle after entry.
  - Pipeline obligation: wb_we_i may be high for at most 3 further cycles (drain), then stays 0 while stall holds.
  - Grant occurs on the first wb_we_i=0 cycle.
  - pipe_stall_o is deasserted in the ACK cycle.
- dbg_req_i dropped while in WAIT/STALL is illegal. The bench asserts against it.
- starve_cnt saturates at STARVE_MAX and never wraps.
- Same-cycle WB and debug access to the same index: WB completes first; the debug read in a later cycle returns the WB value.
- Reset mid-operation: any pending grant or ACK is abandoned, no write is issued, and no ack pulse is emitted.

Decomposition:
- Package rf_arb_pkg holds:
  - state enum rf_arb_state_t {IDLE, WAIT, STALL, ACK}
  - function clog2-based STARVE_W
  - constant RF_X0 = 0
- Sub-module rf_arb_starve_cnt: saturating counter with clr/inc inputs and a hit output at STARVE_MAX.

Test Plan:
- Debug write x5=0xDEADBEEF, wb_we_i=0 -> rf_we_o=1, rf_dst_o=5 at N; dbg_ack_o=1 at N+1; a following read returns 0xDEADBEEF.
- Debug read x0 with rf_rd_q_i forced 0x1234 -> dbg_ack_o at N+1 with dbg_rdata_o=0. Debug write x0 -> rf_we_o stays 0 and ack is still given.
- WB writes x7=0x11 and debug write x7=0x22 in the same cycle -> WB write first, debug write next free cycle; final x7=0x22, ack 1 cycle after the debug write.
- wb_we_i held high, STARVE_MAX=8 -> pipe_stall_o rises after 8 blocked cycles; wb_we_i drops 2 cycles later -> grant that cycle, ack next, stall low in the ACK cycle.
- rst pulsed in the ACK-pending cycle of a read -> dbg_ack_o never pulses, state IDLE, pipe_stall_o=0, starve_cnt=0.
- Back-to-back requests with dbg_req_i held through ack -> second op granted no earlier than ack cycle+1; acks spaced >=2 cycles.
